// File: rtl/display_scan_if.sv
// Signal bundle between the clock/time block and the 4-digit display scanner.
// The master supplies the BCD digits and display options; the slave drives the LED pins.
interface display_scan_if;
    logic [3:0] hourTens;
    logic [3:0] hourMu;
    logic [3:0] minTens;
    logic [3:0] minMu;
    logic       colon;
    logic       blankLeadZero;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hourTens, hourMu, minTens, minMu, colon, blankLeadZero,
        input  an, seg, dp
    );

    modport slave (
        input  hourTens, hourMu, minTens, minMu, colon, blankLeadZero,
        output an, seg, dp
    );
endinterface

// File: rtl/display_scan.sv
// Multiplexed 4-digit 7-segment scanner with per-slot anti-ghosting blanking,
// frame-aligned input snapshot, colon on the decimal point and leading-zero suppression.
module display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic           clk,
    input  logic           resetN,
    display_scan_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic [1:0]    dig;

    logic [3:0] snap_ht;
    logic [3:0] snap_hm;
    logic [3:0] snap_mt;
    logic [3:0] snap_mm;
    logic       snap_colon;
    logic       snap_blz;

    logic [3:0] an_q;
    logic [6:0] seg_q;
    logic       dp_q;

    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;
    logic [3:0] cur_digit;
    logic       in_blank;
    logic       lead_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next output values are computed from the current cnt/dig/snapshot and registered below.
    always_comb begin
        cur_digit = snap_mm;
        case (dig)
            2'd0: cur_digit = snap_mm;
            2'd1: cur_digit = snap_mt;
            2'd2: cur_digit = snap_hm;
            2'd3: cur_digit = snap_ht;
            default: cur_digit = snap_mm;
        endcase

        in_blank   = (cnt < CW'(BLANK_CYC));
        lead_blank = (dig == 2'd3) && snap_blz && (snap_ht == 4'd0);

        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;

        if (!in_blank && !lead_blank) begin
            an_next  = ~(4'b0001 << dig);
            seg_next = decode(cur_digit);
        end

        if (!in_blank && (dig == 2'd2) && snap_colon) begin
            dp_next = 1'b0;
        end
    end

    // The snapshot is taken only at the very start of a frame so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt        <= '0;
            dig        <= 2'd0;
            snap_ht    <= 4'd0;
            snap_hm    <= 4'd0;
            snap_mt    <= 4'd0;
            snap_mm    <= 4'd0;
            snap_colon <= 1'b0;
            snap_blz   <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
        end else begin
            if (cnt == CW'(SCAN_DIV - 1)) begin
                cnt <= '0;
                dig <= dig + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if ((cnt == '0) && (dig == 2'd0)) begin
                snap_ht    <= bus.hourTens;
                snap_hm    <= bus.hourMu;
                snap_mt    <= bus.minTens;
                snap_mm    <= bus.minMu;
                snap_colon <= bus.colon;
                snap_blz   <= bus.blankLeadZero;
            end

            an_q  <= an_next;
            seg_q <= seg_next;
            dp_q  <= dp_next;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_display_scan.sv
// Directed, table-driven bench for display_scan with SCAN_DIV=8, BLANK_CYC=2.
// Position q counts cycles from the first cycle after reset release; outputs seen in cycle q+1 reflect position q.
module tb_display_scan;
    localparam int SD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic resetN = 1'b0;

    display_scan_if bus();

    display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      hT;
        logic [3:0]      hM;
        logic [3:0]      mT;
        logic [3:0]      mM;
        logic            colon;
        logic            blz;
        logic [3:0][6:0] segs;
        logic [3:0][3:0] ans;
    } vec_t;

    int nChecks = 0;
    int nFail   = 0;

    function automatic vec_t mk(input logic [3:0] hT, hM, mT, mM, input logic colon, blz,
                                input logic [6:0] s0, s1, s2, s3,
                                input logic [3:0] a0, a1, a2, a3);
        vec_t v;
        v.hT = hT; v.hM = hM; v.mT = mT; v.mM = mM;
        v.colon = colon; v.blz = blz;
        v.segs[0] = s0; v.segs[1] = s1; v.segs[2] = s2; v.segs[3] = s3;
        v.ans[0] = a0;  v.ans[1] = a1;  v.ans[2] = a2;  v.ans[3] = a3;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.hourTens      = v.hT;
        bus.hourMu        = v.hM;
        bus.minTens       = v.mT;
        bus.minMu         = v.mM;
        bus.colon         = v.colon;
        bus.blankLeadZero = v.blz;
    endtask

    // Expected outputs at scan position q for a frame whose snapshot is described by v.
    task automatic checkOutput(input int q, input vec_t v, input string tag);
        int s, p;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        s = (q / SD) % 4;
        p = q % SD;
        if (p < BC) begin
            ea = 4'b1111; es = 7'b1111111; ed = 1'b1;
        end else begin
            ea = v.ans[s]; es = v.segs[s];
            ed = (s == 2 && v.colon) ? 1'b0 : 1'b1;
        end
        cmp($sformatf("%s q=%0d an", tag, q), {3'b000, bus.an}, {3'b000, ea});
        cmp($sformatf("%s q=%0d seg", tag, q), bus.seg, es);
        cmp($sformatf("%s q=%0d dp", tag, q), {6'b0, bus.dp}, {6'b0, ed});
    endtask

    task automatic restart(input vec_t v, input string tag);
        resetN = 1'b0;
        applyStimulus(v);
        step();
        cmp({tag, " reset an"}, {3'b000, bus.an}, 7'b0001111);
        cmp({tag, " reset seg"}, bus.seg, 7'b1111111);
        cmp({tag, " reset dp"}, {6'b0, bus.dp}, 7'b0000001);
        resetN = 1'b1;
    endtask

    vec_t vecs[5];
    vec_t vA, vB, vR;
    int lowCnt[4];
    int overlap;

    initial begin
        vecs[0] = mk(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0,
                     7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001,
                     4'b1110, 4'b1101, 4'b1011, 4'b0111);
        vecs[1] = mk(4'd0, 4'd5, 4'd5, 4'd9, 1'b0, 1'b1,
                     7'b0010000, 7'b0010010, 7'b0010010, 7'b1111111,
                     4'b1110, 4'b1101, 4'b1011, 4'b1111);
        vecs[2] = mk(4'd0, 4'd5, 4'd5, 4'd9, 1'b0, 1'b0,
                     7'b0010000, 7'b0010010, 7'b0010010, 7'b1000000,
                     4'b1110, 4'b1101, 4'b1011, 4'b0111);
        vecs[3] = mk(4'd0, 4'd6, 4'd7, 4'hC, 1'b1, 1'b1,
                     7'b0111111, 7'b1111000, 7'b0000010, 7'b1111111,
                     4'b1110, 4'b1101, 4'b1011, 4'b1111);
        vecs[4] = mk(4'd8, 4'hF, 4'hA, 4'd0, 1'b0, 1'b1,
                     7'b1000000, 7'b0111111, 7'b0111111, 7'b0000000,
                     4'b1110, 4'b1101, 4'b1011, 4'b0111);

        // Table: one full frame per vector straight after reset release.
        for (int i = 0; i < 5; i++) begin
            restart(vecs[i], $sformatf("vec%0d", i));
            for (int k = 1; k <= 4 * SD; k++) begin
                step();
                checkOutput(k - 1, vecs[i], $sformatf("vec%0d", i));
            end
        end

        // Mid-frame input change must wait for the next frame's snapshot.
        vA = mk(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b0,
                7'b0010010, 7'b0110000, 7'b0100100, 7'b1111001,
                4'b1110, 4'b1101, 4'b1011, 4'b0111);
        vB = vA;
        vB.mM = 4'd7;
        vB.segs[0] = 7'b1111000;
        restart(vA, "midchg");
        for (int k = 1; k <= 5 * SD; k++) begin
            step();
            checkOutput(k - 1, (k - 1 < 4 * SD) ? vA : vB, "midchg");
            if (k == 10) bus.minMu = 4'd7;
        end

        // One-cycle reset pulse during slot 2, then a fresh frame with new inputs.
        restart(vecs[0], "rstmid");
        for (int k = 1; k <= 20; k++) begin
            step();
        end
        vR = vecs[0];
        vR.mM = 4'd9;
        vR.segs[0] = 7'b0010000;
        restart(vR, "rstmid");
        for (int k = 1; k <= 2 * SD; k++) begin
            step();
            checkOutput(k - 1, vR, "rstmid");
        end

        // Three frames: each anode low 6 cycles per frame, never two at once.
        restart(vecs[0], "frames");
        overlap = 0;
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < 4; a++) lowCnt[a] = 0;
            for (int k = 0; k < 4 * SD; k++) begin
                step();
                for (int a = 0; a < 4; a++) begin
                    if (bus.an[a] == 1'b0) lowCnt[a]++;
                end
                if ($countones(~bus.an) > 1) overlap++;
            end
            for (int a = 0; a < 4; a++) begin
                cmp($sformatf("frame%0d an%0d lowcycles", f, a), 7'(lowCnt[a]), 7'd6);
            end
        end
        cmp("frames overlap", 7'(overlap), 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 4..65535.
REQ-002 Parameter BLANK_CYC, default 500: cycles at slot start with all anodes off (anti-ghosting); legal range 1..SCAN_DIV-1.
REQ-003 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-004 resetN  input  1  synchronous, active-low reset.
REQ-005 hourTens  input  4  BCD hour tens digit from clock block.
REQ-006 hourMu  input  4  BCD hour units digit.
REQ-007 minTens  input  4  BCD minute tens digit.
REQ-008 minMu  input  4  BCD minute units digit.
REQ-009 colon  input  1  1 = colon lit.
REQ-010 blankLeadZero  input  1  1 = suppress hourTens digit when it is 0.
REQ-011 an  output  4  active-low anode enables; an[0]=minMu, an[1]=minTens, an[2]=hourMu, an[3]=hourTens.
REQ-012 seg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-013 dp  output  1  active-low decimal point, used as the colon.

Function
REQ-014 Internal slot counter cnt (0..SCAN_DIV-1) SHALL increment every cycle, wrapping SCAN_DIV-1 -> 0.
REQ-015 Internal digit index dig (0..3) SHALL increment when cnt wraps; dig 3 -> 0 on wrap.
REQ-016 Snapshot registers (four digits, colon, blankLeadZero) SHALL load from the inputs on every cycle with cnt==0 and dig==0; inputs are ignored at all other times (no tearing within a frame).
REQ-017 All outputs SHALL be registered; outputs in cycle t+1 reflect cnt/dig/snapshot as held in cycle t.
REQ-018 While cnt < BLANK_CYC: an=4'b1111, seg=7'b1111111, dp=1.
REQ-019 While cnt >= BLANK_CYC: an = all ones except bit dig driven 0, seg = decode of the snapshot digit selected by dig.
REQ-020 Decode (bits {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 Non-BCD value (10..15) SHALL display a dash: seg=0111111.
REQ-022 dp SHALL be 0 only when dig==2, cnt >= BLANK_CYC and snapshot colon==1; otherwise 1.
REQ-023 When dig==3, snapshot blankLeadZero==1 and snapshot hourTens==0: an=4'b1111 and seg=7'b1111111 for the whole slot; slot timing unchanged.
REQ-024 Input changes mid-frame SHALL take effect only from the next frame's snapshot (next cnt==0, dig==0).
REQ-025 Full frame period SHALL be exactly 4*SCAN_DIV cycles; no cycle is skipped or repeated at any wrap.

Reset
REQ-026 While resetN==0 at a rising edge: cnt=0, dig=0, snapshots=0, an=4'b1111, seg=7'b1111111, dp=1.
REQ-027 First cycle with resetN==1 SHALL be cnt=0, dig=0 and SHALL load the snapshot (REQ-016).
REQ-028 Reset asserted mid-slot or mid-frame SHALL abort the scan; outputs return to reset values on the next edge with no partial-digit glitch afterwards.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-029 Inputs 1,2,3,4 (hourTens..minMu), colon=1 -> per frame: an=1110 seg=0011001 cycles 3-8 after reset release, then 1101/0110000, 1011/0100100 with dp=0, 0111/1111001; an=1111 for 2 cycles at each slot start.
REQ-030 hourTens=0, blankLeadZero=1 -> an stays 1111 for all of slot 3; with blankLeadZero=0 same input -> an=0111 seg=1000000.
REQ-031 minMu=4'hC -> slot 0 shows seg=0111111 (dash).
REQ-032 Change minMu 5->7 during slot 1 -> remaining frame unchanged; 7 (1111000) first appears in slot 0 of next frame.
REQ-033 resetN pulsed low for 1 cycle during slot 2 -> next cycle an=1111, seg=1111111, dp=1; scan restarts at slot 0 with a fresh snapshot.
REQ-034 Run 3 frames: each anode low exactly 6 cycles per 32-cycle frame, never two anodes low simultaneously.
